// File: rtl/sync_fifo_level_pkg.sv
// Types and helpers shared by the single-clock level-tracking FIFO.
package sync_fifo_level_pkg;

  // Encoding is {push, pop}, so the helper below is a plain cast.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    return fifo_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/fifo_defs.vh
// Shared FIFO definitions: capacity macro and read-mode selectors, reused by FIFO variants.
`ifndef FIFO_DEFS_VH
`define FIFO_DEFS_VH

`define FIFO_DEPTH(aw) (1 << (aw))
`define FIFO_STD  0
`define FIFO_FWFT 1

`endif

// File: rtl/sync_fifo_mem.sv
// Simple dual-port single-clock RAM with registered, enabled read; infers block RAM.
module sync_fifo_mem #(
  parameter int data_width = 16,
  parameter int addr_width = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic                  re,
  input  logic [addr_width-1:0] raddr,
  output logic [data_width-1:0] rdata
);

  logic [data_width-1:0] mem_reg [0:(1 << addr_width)-1];
  logic [data_width-1:0] rdata_reg;

  // No reset on the array or read register so the tools can map both into the RAM primitive.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem_reg[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/sync_fifo_level.sv
// Single-clock FIFO with exact fill level, programmable almost flags, optional FWFT read
// and sticky overflow/underflow flags.
`include "fifo_defs.vh"

module sync_fifo_level
  import sync_fifo_level_pkg::*;
#(
  parameter int data_width    = 16,
  parameter int addr_width    = 8,
  parameter int fwft          = 0,
  parameter int afull_thresh  = (1 << addr_width) - 4,
  parameter int aempty_thresh = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [data_width-1:0] wdata,
  input  logic                  winc,
  output logic                  wfull,
  output logic                  walmost_full,
  input  logic                  rinc,
  output logic [data_width-1:0] rdata,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [addr_width:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam logic [addr_width:0] depth_lv = (addr_width + 1)'(`FIFO_DEPTH(addr_width));
  localparam bit is_fwft = (fwft == `FIFO_FWFT);

  logic [addr_width:0]   wptr_reg, rptr_reg, level_reg;
  logic                  wfull_reg, walmost_full_reg, rempty_reg, ralmost_empty_reg;
  logic                  overflow_reg, underflow_reg;
  logic                  shown_reg;

  logic                  wr_accept, rd_accept, mem_rd_en;
  logic [addr_width:0]   mem_count, level_next;
  logic                  stage_valid_next, rempty_next;
  logic [data_width-1:0] mem_rdata;

  sync_fifo_mem #(
    .data_width(data_width),
    .addr_width(addr_width)
  ) u_mem (
    .clk  (clk),
    .we   (wr_accept),
    .waddr(wptr_reg[addr_width-1:0]),
    .wdata(wdata),
    .re   (mem_rd_en),
    .raddr(rptr_reg[addr_width-1:0]),
    .rdata(mem_rdata)
  );

  always_comb begin
    wr_accept = winc & ~wfull_reg;
    rd_accept = rinc & ~rempty_reg;
    mem_count = wptr_reg - rptr_reg;

    // In FWFT mode the RAM read register is the output stage: refill it when it is empty or being popped.
    if (is_fwft) begin
      mem_rd_en = (mem_count != '0) && (rempty_reg || rd_accept);
    end else begin
      mem_rd_en = rd_accept;
    end

    unique case (fifo_op(wr_accept, rd_accept))
      OP_PUSH: level_next = level_reg + 1'b1;
      OP_POP:  level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase

    stage_valid_next = mem_rd_en | (~rempty_reg & ~rd_accept);
    rempty_next      = is_fwft ? ~stage_valid_next : (level_next == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_reg          <= '0;
      rptr_reg          <= '0;
      level_reg         <= '0;
      wfull_reg         <= 1'b0;
      walmost_full_reg  <= (afull_thresh <= 0);
      rempty_reg        <= 1'b1;
      ralmost_empty_reg <= 1'b1;
      overflow_reg      <= 1'b0;
      underflow_reg     <= 1'b0;
      shown_reg         <= 1'b0;
    end else begin
      if (wr_accept) wptr_reg <= wptr_reg + 1'b1;
      if (mem_rd_en) rptr_reg <= rptr_reg + 1'b1;
      if (mem_rd_en) shown_reg <= 1'b1;
      level_reg         <= level_next;
      wfull_reg         <= (level_next == depth_lv);
      walmost_full_reg  <= (32'(level_next) >= afull_thresh);
      ralmost_empty_reg <= (32'(level_next) <= aempty_thresh);
      rempty_reg        <= rempty_next;
      // A new rejected request outranks a same-edge clear.
      overflow_reg      <= (winc & wfull_reg) | (overflow_reg & ~err_clr);
      underflow_reg     <= (rinc & rempty_reg) | (underflow_reg & ~err_clr);
    end
  end

  assign wfull         = wfull_reg;
  assign walmost_full  = walmost_full_reg;
  assign rempty        = rempty_reg;
  assign ralmost_empty = ralmost_empty_reg;
  assign level         = level_reg;
  assign overflow      = overflow_reg;
  assign underflow     = underflow_reg;
  // Stale RAM output is hidden until the first read after reset.
  assign rdata         = shown_reg ? mem_rdata : '0;

endmodule

// File: tb/tb_sync_fifo_level.sv
// Drives a standard-mode and an FWFT-mode FIFO with the same stimulus and checks both
// against queue-based reference models every cycle.
module tb_sync_fifo_level;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFULL = DEPTH - 4;
  localparam int AEMPTY = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          winc = 1'b0, rinc = 1'b0, err_clr = 1'b0;

  logic          s_wfull, s_afull, s_rempty, s_aempty, s_ovf, s_udf;
  logic [DW-1:0] s_rdata;
  logic [AW:0]   s_level;
  logic          f_wfull, f_afull, f_rempty, f_aempty, f_ovf, f_udf;
  logic [DW-1:0] f_rdata;
  logic [AW:0]   f_level;

  sync_fifo_level #(.data_width(DW), .addr_width(AW), .fwft(0)) dut_std (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .wfull(s_wfull),
    .walmost_full(s_afull), .rinc(rinc), .rdata(s_rdata), .rempty(s_rempty),
    .ralmost_empty(s_aempty), .level(s_level), .overflow(s_ovf), .underflow(s_udf),
    .err_clr(err_clr)
  );

  sync_fifo_level #(.data_width(DW), .addr_width(AW), .fwft(1)) dut_ff (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .wfull(f_wfull),
    .walmost_full(f_afull), .rinc(rinc), .rdata(f_rdata), .rempty(f_rempty),
    .ralmost_empty(f_aempty), .level(f_level), .overflow(f_ovf), .underflow(f_udf),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: each queue holds every word the FIFO counts in its level, head first.
  logic [DW-1:0] sq[$];
  logic [DW-1:0] fq[$];
  logic [DW-1:0] s_rd_m;
  bit            s_ov_m, s_uf_m, f_ov_m, f_uf_m;
  bit            f_stage_m, f_shown_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_edge();
    bit full, empty, wa, ra;
    int behind;
    if (!rst_n) begin
      sq.delete(); fq.delete();
      s_rd_m = '0;
      s_ov_m = 0; s_uf_m = 0; f_ov_m = 0; f_uf_m = 0;
      f_stage_m = 0; f_shown_m = 0;
    end else begin
      full  = (sq.size() == DEPTH);
      empty = (sq.size() == 0);
      wa = winc && !full;
      ra = rinc && !empty;
      s_ov_m = (winc && full) || (s_ov_m && !err_clr);
      s_uf_m = (rinc && empty) || (s_uf_m && !err_clr);
      if (ra) s_rd_m = sq.pop_front();
      if (wa) sq.push_back(wdata);

      full   = (fq.size() == DEPTH);
      empty  = !f_stage_m;
      behind = fq.size() - (f_stage_m ? 1 : 0);
      wa = winc && !full;
      ra = rinc && !empty;
      f_ov_m = (winc && full) || (f_ov_m && !err_clr);
      f_uf_m = (rinc && empty) || (f_uf_m && !err_clr);
      if (ra) fq.delete(0);
      if (wa) fq.push_back(wdata);
      if (ra || !f_stage_m) begin
        f_stage_m = (behind > 0);
        if (behind > 0) f_shown_m = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("std_level",  32'(s_level),  32'(sq.size()));
    chk("std_wfull",  32'(s_wfull),  32'(sq.size() == DEPTH));
    chk("std_afull",  32'(s_afull),  32'(sq.size() >= AFULL));
    chk("std_rempty", 32'(s_rempty), 32'(sq.size() == 0));
    chk("std_aempty", 32'(s_aempty), 32'(sq.size() <= AEMPTY));
    chk("std_ovf",    32'(s_ovf),    32'(s_ov_m));
    chk("std_udf",    32'(s_udf),    32'(s_uf_m));
    chk("std_rdata",  32'(s_rdata),  32'(s_rd_m));
    chk("ff_level",   32'(f_level),  32'(fq.size()));
    chk("ff_wfull",   32'(f_wfull),  32'(fq.size() == DEPTH));
    chk("ff_afull",   32'(f_afull),  32'(fq.size() >= AFULL));
    chk("ff_rempty",  32'(f_rempty), 32'(!f_stage_m));
    chk("ff_aempty",  32'(f_aempty), 32'(fq.size() <= AEMPTY));
    chk("ff_ovf",     32'(f_ovf),    32'(f_ov_m));
    chk("ff_udf",     32'(f_udf),    32'(f_uf_m));
    if (f_stage_m) chk("ff_rdata", 32'(f_rdata), 32'(fq[0]));
    else if (!f_shown_m) chk("ff_rdata_rst", 32'(f_rdata), 32'd0);
  endtask

  // One clock edge: update the model from the inputs present at the edge, then sample 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    $display("t=%0t rst_n=%0b winc=%0b rinc=%0b clr=%0b wdata=%h | std lvl=%0d rd=%h | ff lvl=%0d rd=%h",
             $time, rst_n, winc, rinc, err_clr, wdata, s_level, s_rdata, f_level, f_rdata);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int lvl0;
    int pw;

    // Reset, then idle.
    do_reset();
    cycle();
    repeat (2) cycle();
    chk("idle_rempty", 32'(s_rempty), 32'd1);
    chk("idle_level", 32'(s_level), 32'd0);

    // Fill with 1..8, then one extra write.
    for (int i = 1; i <= DEPTH; i++) begin
      winc = 1'b1; wdata = DW'(i);
      cycle();
      if (i == AFULL) chk("afull_at_4", 32'(s_afull), 32'd1);
    end
    chk("fill_level", 32'(s_level), 32'(DEPTH));
    chk("fill_wfull", 32'(s_wfull), 32'd1);
    wdata = 16'h0009;
    cycle();
    chk("ovf_set", 32'(s_ovf), 32'd1);
    winc = 1'b0;

    // Drain, then one read too many.
    for (int i = 1; i <= DEPTH; i++) begin
      rinc = 1'b1;
      cycle();
      chk("rd_order", 32'(s_rdata), 32'(i));
    end
    chk("drain_rempty", 32'(s_rempty), 32'd1);
    cycle();
    chk("udf_set", 32'(s_udf), 32'd1);
    rinc = 1'b0; err_clr = 1'b1;
    cycle();
    chk("clr_udf", 32'(s_udf), 32'd0);
    chk("clr_ovf", 32'(s_ovf), 32'd0);
    rinc = 1'b1;
    cycle();
    chk("clr_vs_err", 32'(s_udf), 32'd1);
    rinc = 1'b0; err_clr = 1'b0;
    cycle();

    // FWFT single-word latency.
    do_reset();
    cycle();
    winc = 1'b1; wdata = 16'hA5A5;
    cycle();
    winc = 1'b0;
    chk("ff_lat_n", 32'(f_rempty), 32'd1);
    cycle();
    chk("ff_lat_n1", 32'(f_rempty), 32'd0);
    chk("ff_lat_data", 32'(f_rdata), 32'hA5A5);

    // Prefill, then stream with simultaneous push/pop.
    for (int i = 0; i < 3; i++) begin
      winc = 1'b1; wdata = DW'(16'h1000 + i);
      cycle();
    end
    winc = 1'b0;
    cycle();
    lvl0 = int'(f_level);
    for (int i = 0; i < 40; i++) begin
      winc = 1'b1; rinc = 1'b1; wdata = DW'(16'h2000 + i);
      cycle();
      chk("stream_level", 32'(f_level), 32'(lvl0));
      chk("stream_nobubble", 32'(f_rempty), 32'd0);
    end
    winc = 1'b0; rinc = 1'b0;

    // Full with both requests.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      winc = 1'b1; wdata = DW'(16'h3000 + i);
      cycle();
    end
    rinc = 1'b1; wdata = 16'h3FFF;
    cycle();
    chk("full_both_std_lvl", 32'(s_level), 32'(DEPTH - 1));
    chk("full_both_ff_lvl", 32'(f_level), 32'(DEPTH - 1));
    chk("full_both_ovf", 32'(s_ovf), 32'd1);
    chk("full_both_head", 32'(s_rdata), 32'h3000);

    // Empty with both requests.
    do_reset();
    winc = 1'b1; rinc = 1'b1; wdata = 16'h4444;
    cycle();
    chk("empty_both_std_lvl", 32'(s_level), 32'd1);
    chk("empty_both_ff_lvl", 32'(f_level), 32'd1);
    chk("empty_both_udf", 32'(f_udf), 32'd1);
    winc = 1'b0; rinc = 1'b0;

    // Random traffic with phase-varying bias, error clears and a mid-stream reset.
    do_reset();
    pw = 50;
    for (int c = 0; c < 1000; c++) begin
      if (c % 100 == 0) pw = (c / 100) % 3 == 0 ? 80 : ((c / 100) % 3 == 1 ? 20 : 50);
      winc    = ($urandom_range(0, 99) < pw);
      rinc    = ($urandom_range(0, 99) < (100 - pw));
      err_clr = ($urandom_range(0, 99) < 5);
      wdata   = DW'($urandom);
      rst_n   = (c != 500);
      cycle();
      if (c == 500) chk("midrst_level", 32'(f_level), 32'd0);
    end
    winc = 1'b0; rinc = 1'b0; err_clr = 1'b0; rst_n = 1'b1;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_level.md
Name: sync_fifo_level

Overview:
- Single-clock, parametrised FIFO for same-domain buffering, e.g. CCD pixel words from the readout sequencer to the USB/serial packer.
- Provides:
  - an exact fill level;
  - programmable almost-full/almost-empty flags;
  - selectable standard or first-word-fall-through (FWFT) read mode;
  - sticky overflow/underflow error flags.
- No Gray-code or synchroniser logic: both pointers live in one clock domain.

Parameters:
- data_width, 16, word width in bits.
- addr_width, 8, log2 of capacity; DEPTH = 2**addr_width words.
- fwft, 0, 0 = standard registered read, 1 = first-word-fall-through.
- afull_thresh, 2**addr_width-4, walmost_full asserted when level >= afull_thresh.
- aempty_thresh, 4, ralmost_empty asserted when level <= aempty_thresh.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- wdata  in  data_width  write data.
- winc  in  1  write request.
- wfull  out  1  FIFO holds DEPTH words.
- walmost_full  out  1  level >= afull_thresh.
- rinc  in  1  read request / pop.
- rdata  out  data_width  read data.
- rempty  out  1  no word readable.
- ralmost_empty  out  1  level <= aempty_thresh.
- level  out  addr_width+1  words currently held, 0..DEPTH.
- overflow  out  1  sticky: write attempted while wfull.
- underflow  out  1  sticky: read attempted while rempty.
- err_clr  in  1  clears overflow/underflow.

Behaviour:
- Reset (rst_n low at a clk edge), all values:
  - wptr = rptr = 0, level = 0;
  - rempty = 1, ralmost_empty = 1;
  - wfull = 0, walmost_full = 0 unless afull_thresh = 0;
  - overflow = underflow = 0;
  - rdata = 0;
  - FWFT output stage invalid.
- Reset mid-operation discards all contents; memory array is not cleared.
- Accept rules:
  - write accepted iff winc & !wfull;
  - read accepted iff rinc & !rempty.
  - Flags are the registered values at the edge.
- Pointers: binary, addr_width+1 bits, wrap modulo 2*DEPTH; memory address = low addr_width bits.
- level:
  - registered;
  - +1 on write-only, -1 on read-only, unchanged on both or neither;
  - never exceeds DEPTH or goes below 0.
- Flag derivation:
  - wfull = (level == DEPTH);
  - walmost_full and ralmost_empty are compares on the next-state level, so all flags update on the same edge as level.
- Simultaneous winc & rinc:
  - when full: read accepted, write rejected, overflow set, level = DEPTH-1;
  - when empty: write accepted, read rejected, underflow set, level = 1;
  - otherwise both accepted, level unchanged.
- Standard mode (fwft = 0):
  - rempty = (level == 0);
  - write at edge N makes rempty low after edge N;
  - accepted read at edge M loads rdata with the head word after edge M;
  - rdata holds its value until the next accepted read.
- FWFT mode (fwft = 1):
  - one output register holds the head word;
  - rempty = !stage_valid, and rdata is valid whenever rempty = 0;
  - write into an empty FIFO at edge N: word in memory after N, moves to the stage after N+1, rempty low after N+1;
  - accepted rinc pops the stage; if memory is non-empty, the stage refills on the same edge, so back-to-back reads run at 1 word/clk;
  - level counts stage plus memory; total capacity stays DEPTH.
- Error flags:
  - set on a rejected request, held until err_clr;
  - err_clr and a new error on the same edge: error wins.
- Pointer wrap: no loss or duplication across 2*DEPTH pointer wrap.

Decomposition:
- Shared include fifo_defs.vh holds the DEPTH localparam macro and the mode constants FIFO_STD / FIFO_FWFT, for reuse by future FIFO variants.
- One sub-module, sync_fifo_mem:
  - simple dual-port, single clock;
  - write enable = accepted write;
  - registered read with read enable;
  - maps to iCE40 block RAM.
- Pointer/level/flag logic and the FWFT stage stay in the top module.

Test Plan:
- Reset, then idle → level = 0, rempty = 1, wfull = 0, ralmost_empty = 1, rdata = 0, both error flags 0.
- addr_width = 3, fwft = 0: write 8 words 0x0001..0x0008 → wfull = 1 and level = 8 after 8th edge, walmost_full from level = 4; 9th write sets overflow; 8 reads return 0x0001..0x0008, each 1 clk after rinc; rempty after 8th read.
- Same config: 9th rinc while empty sets underflow; err_clr pulse clears both flags; err_clr together with a new rejected read leaves underflow = 1.
- fwft = 1: single write 0xA5A5 at edge N → rempty low after N+1 with rdata = 0xA5A5 before any rinc; continuous winc & rinc for 40 cycles → level constant, data in order, no bubbles.
- Full FIFO with winc & rinc on one edge → head word popped, write rejected, overflow = 1, level = 7; empty FIFO with both → write accepted, underflow = 1, level = 1.
- 1000-cycle random winc/rinc vs. reference queue model, both modes → data, level and all flags match every cycle, including across 2*DEPTH pointer wrap; rst_n low mid-stream → empty state next cycle.
